// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller: opcodes,
// branch-compare operand select encodings and the stall FSM state.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_WB    = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // True when the instruction in ID uses its Rt field as a source.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/branch_fwd_sel.sv
// Operand select for the ID-stage branch comparator: forward from EX/MEM
// (ALU results only) in preference to MEM/WB, else use the register file.
module branch_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] exmem_reg,
  input  logic       exmem_we,
  input  logic       exmem_re,
  input  logic [4:0] wb_reg,
  input  logic       wb_we,
  output logic [1:0] sel
);

  always_comb begin
    sel = SEL_REG;
    // A load still in MEM has no data yet, so it is never a forwarding source.
    if (src != 5'd0 && src == exmem_reg && exmem_we && !exmem_re)
      sel = SEL_EXMEM;
    else if (src != 5'd0 && src == wb_reg && wb_we)
      sel = SEL_WB;
  end

endmodule

// File: rtl/hazard_controller.sv
// Load-use and branch hazard detection with stall FSM and branch forwarding
// selects. Optional stall/flush counters are enabled by HAZARD_STATS_EN.
module hazard_controller
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] IFIDopCode,
  input  logic [4:0] IFIDRs,
  input  logic [4:0] IFIDRt,
  input  logic [4:0] IDExRt,
  input  logic [4:0] IDExRd,
  input  logic       IDExReg_dst,
  input  logic       IDExWriteRegEnable,
  input  logic       IDExReadMemoryEnable,
  input  logic [4:0] EXMEMwritereg,
  input  logic       EXMEMWriteRegEnable,
  input  logic       EXMEMReadMemoryEnable,
  input  logic [4:0] MemWBwritereg,
  input  logic       MemWBWriteRegEnable,
  input  logic       branchResult,
  output logic       stall,
  output logic       IDEXFlush,
  output logic       IFIDFlush,
  output logic [1:0] CompSel1,
  output logic [1:0] CompSel2
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
`endif
);

  state_t     state;
  logic [4:0] ex_dest;
  logic       is_beq;
  logic       rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic       load_use, beq_alu, beq_load_ex, beq_load_mem;
  logic       hazard_1, hazard_2;
  logic [1:0] sel1_raw, sel2_raw;

  assign ex_dest = IDExReg_dst ? IDExRd : IDExRt;
  assign is_beq  = (IFIDopCode == OP_BEQ);

  // Register 0 is hard-wired, so it never creates a dependency.
  assign rs_hit_ex  = (IFIDRs != 5'd0) && (IFIDRs == ex_dest);
  assign rt_hit_ex  = reads_rt(IFIDopCode) && (IFIDRt != 5'd0) && (IFIDRt == ex_dest);
  assign rs_hit_mem = (IFIDRs != 5'd0) && (IFIDRs == EXMEMwritereg);
  assign rt_hit_mem = (IFIDRt != 5'd0) && (IFIDRt == EXMEMwritereg);

  assign load_use     = IDExReadMemoryEnable && (rs_hit_ex || rt_hit_ex);
  assign beq_alu      = is_beq && IDExWriteRegEnable && !IDExReadMemoryEnable &&
                        (rs_hit_ex || rt_hit_ex);
  assign beq_load_ex  = is_beq && load_use;
  assign beq_load_mem = is_beq && EXMEMReadMemoryEnable && EXMEMWriteRegEnable &&
                        (rs_hit_mem || rt_hit_mem);

  // The longest requirement wins; only a load feeding a beq from EX needs two.
  assign hazard_2 = beq_load_ex;
  assign hazard_1 = load_use || beq_alu || beq_load_mem;

  // NOTE: reset gates these combinational outputs directly so they read 0 in
  // the reset cycle itself, not one edge later.
  always_comb begin
    stall = 1'b0;
    if (!reset)
      stall = (state == ST_HOLD) || hazard_1 || hazard_2;
  end

  assign IDEXFlush = stall;
  assign IFIDFlush = !reset && !stall && is_beq && branchResult;

  // NOTE: state uses non-blocking assignment so every reader sees the
  // pre-edge value within the same clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:  state <= hazard_2 ? ST_HOLD : ST_RUN;
        ST_HOLD: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  branch_fwd_sel u_sel_rs (
    .src       (IFIDRs),
    .exmem_reg (EXMEMwritereg),
    .exmem_we  (EXMEMWriteRegEnable),
    .exmem_re  (EXMEMReadMemoryEnable),
    .wb_reg    (MemWBwritereg),
    .wb_we     (MemWBWriteRegEnable),
    .sel       (sel1_raw)
  );

  branch_fwd_sel u_sel_rt (
    .src       (IFIDRt),
    .exmem_reg (EXMEMwritereg),
    .exmem_we  (EXMEMWriteRegEnable),
    .exmem_re  (EXMEMReadMemoryEnable),
    .wb_reg    (MemWBwritereg),
    .wb_we     (MemWBWriteRegEnable),
    .sel       (sel2_raw)
  );

  assign CompSel1 = reset ? SEL_REG : sel1_raw;
  assign CompSel2 = reset ? SEL_REG : sel2_raw;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stall && stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
      if (IFIDFlush && flushCount != 16'hFFFF)
        flushCount <= flushCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed pipeline scenarios
// followed by random stimulus against a cycle-count reference model.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] IFIDopCode;
  logic [4:0] IFIDRs, IFIDRt, IDExRt, IDExRd, EXMEMwritereg, MemWBwritereg;
  logic       IDExReg_dst, IDExWriteRegEnable, IDExReadMemoryEnable;
  logic       EXMEMWriteRegEnable, EXMEMReadMemoryEnable, MemWBWriteRegEnable;
  logic       branchResult;
  logic       stall, IDEXFlush, IFIDFlush;
  logic [1:0] CompSel1, CompSel2;
`ifdef HAZARD_STATS_EN
  logic [15:0] stallCount, flushCount;
  int          m_stall_cnt, m_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int hold_left = 0;   // extra stall cycles still owed by the model

  always #5 clk = ~clk;

  hazard_controller dut (
    .clk                   (clk),
    .reset                 (reset),
    .IFIDopCode            (IFIDopCode),
    .IFIDRs                (IFIDRs),
    .IFIDRt                (IFIDRt),
    .IDExRt                (IDExRt),
    .IDExRd                (IDExRd),
    .IDExReg_dst           (IDExReg_dst),
    .IDExWriteRegEnable    (IDExWriteRegEnable),
    .IDExReadMemoryEnable  (IDExReadMemoryEnable),
    .EXMEMwritereg         (EXMEMwritereg),
    .EXMEMWriteRegEnable   (EXMEMWriteRegEnable),
    .EXMEMReadMemoryEnable (EXMEMReadMemoryEnable),
    .MemWBwritereg         (MemWBwritereg),
    .MemWBWriteRegEnable   (MemWBWriteRegEnable),
    .branchResult          (branchResult),
    .stall                 (stall),
    .IDEXFlush             (IDEXFlush),
    .IFIDFlush             (IFIDFlush),
    .CompSel1              (CompSel1),
    .CompSel2              (CompSel2)
`ifdef HAZARD_STATS_EN
    ,
    .stallCount            (stallCount),
    .flushCount            (flushCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Stall cycles the ID instruction needs, straight from the hazard rules.
  function automatic int need_cycles();
    int  n = 0;
    int  dst = IDExReg_dst ? int'(IDExRd) : int'(IDExRt);
    bit  beq = (IFIDopCode == 6'h04);
    bit  rt_read = (IFIDopCode == 6'h00) || beq || (IFIDopCode == 6'h2B);
    bit  ex_hit = (IFIDRs != 0 && IFIDRs == dst) || (rt_read && IFIDRt != 0 && IFIDRt == dst);
    bit  mem_hit = (IFIDRs != 0 && IFIDRs == EXMEMwritereg) ||
                   (IFIDRt != 0 && IFIDRt == EXMEMwritereg);
    if (IDExReadMemoryEnable && ex_hit) n = beq ? 2 : 1;
    if (n < 1 && beq && IDExWriteRegEnable && !IDExReadMemoryEnable && ex_hit) n = 1;
    if (n < 1 && beq && EXMEMReadMemoryEnable && EXMEMWriteRegEnable && mem_hit) n = 1;
    return n;
  endfunction

  function automatic logic [1:0] fwd(input logic [4:0] r);
    if (r != 0 && r == EXMEMwritereg && EXMEMWriteRegEnable && !EXMEMReadMemoryEnable)
      return 2'b01;
    if (r != 0 && r == MemWBwritereg && MemWBWriteRegEnable)
      return 2'b10;
    return 2'b00;
  endfunction

  // Compare one cycle against the model, then advance across a clock edge.
  // exp_stall >= 0 additionally pins the directed expectation.
  task automatic step(input int exp_stall);
    int  n;
    bit  m_stall, m_flush;
    #1;
    n = reset ? 0 : need_cycles();
    m_stall = !reset && (hold_left > 0 || n > 0);
    m_flush = !reset && !m_stall && IFIDopCode == 6'h04 && branchResult;
    check("stall", 32'(stall), 32'(m_stall));
    check("idex_flush", 32'(IDEXFlush), 32'(m_stall));
    check("ifid_flush", 32'(IFIDFlush), 32'(m_flush));
    check("compsel1", 32'(CompSel1), reset ? 32'd0 : 32'(fwd(IFIDRs)));
    check("compsel2", 32'(CompSel2), reset ? 32'd0 : 32'(fwd(IFIDRt)));
    if (exp_stall >= 0) check("directed_stall", 32'(stall), 32'(exp_stall));
`ifdef HAZARD_STATS_EN
    check("stall_count", 32'(stallCount), 32'(m_stall_cnt));
    check("flush_count", 32'(flushCount), 32'(m_flush_cnt));
`endif
    @(posedge clk);
    #1;
    if (reset) hold_left = 0;
    else if (hold_left > 0) hold_left = hold_left - 1;
    else if (n > 1) hold_left = n - 1;
`ifdef HAZARD_STATS_EN
    if (reset) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (m_stall && m_stall_cnt < 65535) m_stall_cnt++;
      if (m_flush && m_flush_cnt < 65535) m_flush_cnt++;
    end
`endif
  endtask

  task automatic clear();
    IFIDopCode = 6'h00; IFIDRs = 0; IFIDRt = 0; IDExRt = 0; IDExRd = 0;
    IDExReg_dst = 0; IDExWriteRegEnable = 0; IDExReadMemoryEnable = 0;
    EXMEMwritereg = 0; EXMEMWriteRegEnable = 0; EXMEMReadMemoryEnable = 0;
    MemWBwritereg = 0; MemWBWriteRegEnable = 0; branchResult = 0;
  endtask

  initial begin
    logic [5:0] ops [5];
    ops[0] = 6'h00; ops[1] = 6'h04; ops[2] = 6'h23; ops[3] = 6'h2B; ops[4] = 6'h08;
`ifdef HAZARD_STATS_EN
    m_stall_cnt = 0;
    m_flush_cnt = 0;
`endif
    clear();
    reset = 1'b1;
    @(negedge clk);
    // Reset state: outputs forced low even with a hazard present.
    IDExRt = 5'd2; IDExReadMemoryEnable = 1; IFIDRs = 5'd2;
    step(0);
    step(0);
    reset = 1'b0;
    clear();
    step(0);

    // lw $2 in EX, add $3,$2,$4 in ID: one stall cycle.
    IDExRt = 5'd2; IDExReadMemoryEnable = 1; IDExWriteRegEnable = 1;
    IFIDopCode = 6'h00; IFIDRs = 5'd2; IFIDRt = 5'd4;
    step(1);
    clear(); IFIDopCode = 6'h00; IFIDRs = 5'd2; IFIDRt = 5'd4;
    EXMEMwritereg = 5'd2; EXMEMReadMemoryEnable = 1; EXMEMWriteRegEnable = 1;
    step(0);

    // lw $5 in EX, beq $5,$6 in ID: two stall cycles via HOLD.
    clear(); IDExRt = 5'd5; IDExReadMemoryEnable = 1; IDExWriteRegEnable = 1;
    IFIDopCode = 6'h04; IFIDRs = 5'd5; IFIDRt = 5'd6;
    step(1);
    clear(); IFIDopCode = 6'h04; IFIDRs = 5'd5; IFIDRt = 5'd6;
    step(1);   // HOLD cycle with no live hazard on the inputs
    MemWBwritereg = 5'd5; MemWBWriteRegEnable = 1;
    step(0);

    // add $7 in MEM, beq $7,$0 taken: forward from EX/MEM, flush IF/ID once.
    clear(); EXMEMwritereg = 5'd7; EXMEMWriteRegEnable = 1;
    IFIDopCode = 6'h04; IFIDRs = 5'd7; IFIDRt = 5'd0; branchResult = 1;
    step(0);
    clear();
    step(0);

    // Same destination in EX/MEM and MEM/WB: EX/MEM wins on both operands.
    EXMEMwritereg = 5'd9; EXMEMWriteRegEnable = 1;
    MemWBwritereg = 5'd9; MemWBWriteRegEnable = 1;
    IFIDopCode = 6'h04; IFIDRs = 5'd9; IFIDRt = 5'd9;
    step(0);

    // Load to $0 never stalls or forwards.
    clear(); IDExRt = 5'd0; IDExReadMemoryEnable = 1; IDExWriteRegEnable = 1;
    EXMEMwritereg = 5'd0; EXMEMWriteRegEnable = 1; MemWBwritereg = 5'd0; MemWBWriteRegEnable = 1;
    IFIDopCode = 6'h00; IFIDRs = 5'd0; IFIDRt = 5'd0;
    step(0);

    // Reset during HOLD aborts the second stall cycle.
    clear(); IDExRd = 5'd3; IDExReg_dst = 1; IDExReadMemoryEnable = 1; IDExWriteRegEnable = 1;
    IFIDopCode = 6'h04; IFIDRs = 5'd1; IFIDRt = 5'd3;
    step(1);
    clear(); reset = 1'b1;
    step(0);
    reset = 1'b0;
    step(0);
`ifdef HAZARD_STATS_EN
    check("stall_count_after_reset", 32'(stallCount), 32'd0);
`endif

    // Random traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 29) == 0);
      IFIDopCode = ops[$urandom_range(0, 4)];
      IFIDRs = 5'($urandom_range(0, 3));
      IFIDRt = 5'($urandom_range(0, 3));
      IDExRt = 5'($urandom_range(0, 3));
      IDExRd = 5'($urandom_range(0, 3));
      IDExReg_dst = 1'($urandom);
      IDExWriteRegEnable = 1'($urandom);
      IDExReadMemoryEnable = ($urandom_range(0, 2) == 0);
      EXMEMwritereg = 5'($urandom_range(0, 3));
      EXMEMWriteRegEnable = 1'($urandom);
      EXMEMReadMemoryEnable = ($urandom_range(0, 2) == 0);
      MemWBwritereg = 5'($urandom_range(0, 3));
      MemWBWriteRegEnable = 1'($urandom);
      branchResult = 1'($urandom);
      step(-1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: `clk` and `reset`.
REQ-002 SHALL have these ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous active-high reset
- `IFIDopCode`  in  6  opcode of the instruction in ID
- `IFIDRs`, `IFIDRt`  in  5 each  source fields of the instruction in ID
- `IDExRt`, `IDExRd`  in  5 each  EX-stage register fields
- `IDExReg_dst`  in  1  EX destination select (1 = Rd, 0 = Rt)
- `IDExWriteRegEnable`, `IDExReadMemoryEnable`  in  1 each  EX control bits
- `EXMEMwritereg`  in  5  MEM-stage destination
- `EXMEMWriteRegEnable`, `EXMEMReadMemoryEnable`  in  1 each  MEM control bits
- `MemWBwritereg`  in  5  WB destination
- `MemWBWriteRegEnable`  in  1  WB write enable
- `branchResult`  in  1  ID-stage equality compare result
- `stall`  out  1  hold PC and IF/ID; zero write enables entering EX
- `IDEXFlush`  out  1  bubble into ID/EX
- `IFIDFlush`  out  1  squash the fetched instruction after a taken branch
- `CompSel1`, `CompSel2`  out  2 each  branch-compare operand selects

Function
REQ-003 SHALL compute the EX destination as `IDExRd` when `IDExReg_dst` = 1, else `IDExRt`.
REQ-004 SHALL treat the ID instruction as reading Rt only for these opcodes: R-type 6'h00, beq 6'h04, sw 6'h2B. Rs SHALL count as read for all opcodes.
REQ-005 SHALL never detect a match on register 0, for any hazard or forward.
REQ-006 SHALL detect load-use: `IDExReadMemoryEnable`=1 and the EX destination matches a register read in ID. Required stall = 1 cycle.
REQ-007 SHALL detect a beq-on-ALU hazard: ID opcode is beq, `IDExWriteRegEnable`=1, `IDExReadMemoryEnable`=0, and the EX destination equals `IFIDRs` or `IFIDRt`. Required stall = 1 cycle.
REQ-008 SHALL detect a beq-on-load hazard in EX (REQ-006 condition with ID opcode beq). Required stall = 2 cycles.
REQ-009 SHALL detect a beq-on-load hazard in MEM: `EXMEMReadMemoryEnable`=1, `EXMEMWriteRegEnable`=1, and `EXMEMwritereg` equals Rs or Rt. Required stall = 1 cycle.
REQ-010 SHALL use a two-state FSM, RUN and HOLD:
- RUN: `stall` is combinational from REQ-006..009. A 2-cycle hazard SHALL move the FSM to HOLD; otherwise it stays in RUN.
- HOLD: `stall`=1 unconditionally for one cycle, then return to RUN.
REQ-011 SHALL drive `IDEXFlush` equal to `stall` in every cycle.
REQ-012 SHALL assert `IFIDFlush`=1 when ID opcode is beq, `branchResult`=1 and `stall`=0. It SHALL be combinational and last one cycle. While `stall`=1, `IFIDFlush` SHALL be 0.
REQ-013 SHALL set `CompSel1` by comparing `IFIDRs` against later-stage destinations, in priority order:
- 01 if `EXMEMwritereg` matches, `EXMEMWriteRegEnable`=1 and `EXMEMReadMemoryEnable`=0;
- else 10 if `MemWBwritereg` matches with `MemWBWriteRegEnable`=1;
- else 00.
`CompSel2` SHALL use the same rules with `IFIDRt`. Encoding 11 SHALL never be driven.
REQ-014 SHALL resolve simultaneous hazards by taking the maximum required stall.

Reset
REQ-015 While `reset`=1 at a clock edge, the FSM SHALL go to RUN and `stall`, `IDEXFlush` and `IFIDFlush` SHALL be forced to 0. A reset asserted while in HOLD SHALL abort the second stall cycle.
REQ-016 `CompSel1` and `CompSel2` SHALL be 00 while `reset`=1.

Configuration
REQ-017 With macro `HAZARD_STATS_EN` defined, the block SHALL add two outputs:
- `stallCount`  out  16  counts cycles with `stall`=1;
- `flushCount`  out  16  counts cycles with `IFIDFlush`=1.
Both SHALL saturate at 16'hFFFF and reset to 0.
REQ-018 Without `HAZARD_STATS_EN`, these ports and counters SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-019 Shared package `hazard_pkg` SHALL hold:
- opcode constants (R-type, beq, lw, sw);
- CompSel encodings (SEL_REG=00, SEL_EXMEM=01, SEL_WB=10);
- the FSM state enum.
REQ-020 Sub-module `branch_fwd_sel` SHALL implement REQ-013 for one operand and SHALL be instantiated twice.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- lw $2 in EX (dest 2), ID `add $3,$2,$4` -> `stall`=`IDEXFlush`=1 for exactly 1 cycle, then 0.
- lw $5 in EX, ID `beq $5,$6` -> `stall`=1 for 2 consecutive cycles (RUN -> HOLD -> RUN).
- add $7 in MEM, ID `beq $7,$0`, `branchResult`=1 -> `CompSel1`=01, `CompSel2`=00, `stall`=0, `IFIDFlush`=1 for 1 cycle.
- EXMEM and MEMWB both dest 9, ID `beq $9,$9` -> `CompSel1`=`CompSel2`=01 (EXMEM priority).
- lw $0 in EX, ID reads $0 -> `stall`=0 and `CompSel`=00.
- `reset` asserted in HOLD -> `stall`=0 on the next cycle, FSM=RUN; with `HAZARD_STATS_EN`, `stallCount` returns to 0.
